// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings and defaults for the I-cache / D-cache main-memory arbiter.
package cache_mem_arbiter_pkg;

  localparam int unsigned ARB_AW    = 28;
  localparam int unsigned ARB_DW    = 128;
  localparam int unsigned ARB_BURST = 4;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_CMD   = 2'd1,
    ARB_RDATA = 2'd2,
    ARB_WDATA = 2'd3
  } arb_state_e;

  // Which cache currently owns the memory port.
  typedef enum logic {
    ARB_OWN_IC = 1'b0,
    ARB_OWN_DC = 1'b1
  } arb_owner_e;

  // Two-way round-robin choice: a lone requester always wins; on a
  // conflict the requester that did not win last time gets the port.
  function automatic arb_owner_e rr2_pick(input logic ic_v, input logic dc_v,
                                          input arb_owner_e last);
    arb_owner_e pick;
    pick = ARB_OWN_IC;
    if (ic_v && dc_v) begin
      if (last == ARB_OWN_IC) pick = ARB_OWN_DC;
      else                    pick = ARB_OWN_IC;
    end else if (dc_v) begin
      pick = ARB_OWN_DC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory handshakes seen by the arbiter.
//
// Handshake semantics (every *_valid / *_ready pair): a transfer happens on
// a rising clock edge where valid and ready are both high. The source holds
// valid and its payload stable until that edge; ready may depend
// combinationally on valid. mem_resp_valid has no ready: the memory pushes
// a read beat and it must be taken in that cycle.
//
// master: the arbiter. slave: the caches and memory around it.
interface cache_mem_arbiter_if #(
  parameter int AW = 28,
  parameter int DW = 128
);
  // I-cache read command and read beats
  logic          ic_req_valid;
  logic          ic_req_ready;
  logic [AW-1:0] ic_req_addr;
  logic          ic_resp_valid;
  logic [DW-1:0] ic_resp_data;

  // D-cache command, write beats and read beats
  logic          dc_req_valid;
  logic          dc_req_ready;
  logic          dc_req_rnw;
  logic [AW-1:0] dc_req_addr;
  logic          dc_wdata_valid;
  logic          dc_wdata_ready;
  logic [DW-1:0] dc_wdata;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_resp_data;

  // Main-memory command, write beats and read beats
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_rnw;
  logic [AW-1:0] mem_req_addr;
  logic          mem_wdata_valid;
  logic          mem_wdata_ready;
  logic [DW-1:0] mem_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;

  modport master (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rnw, dc_req_addr, dc_wdata_valid, dc_wdata,
    output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rnw, mem_req_addr, mem_wdata_valid, mem_wdata,
    input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rnw, dc_req_addr, dc_wdata_valid, dc_wdata,
    input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_wdata_valid, mem_wdata,
    output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/cache_mem_arbiter_rr2.sv
// arb_rr2: two-way round-robin picker that remembers who won the last grant.
module arb_rr2
  import cache_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ic_valid,
  input  logic       dc_valid,
  input  logic       grant_en,   // the owner is latched this cycle
  output logic       gnt_valid,
  output arb_owner_e gnt_owner
);

  arb_owner_e last_q;

  // Candidate winner for this cycle, from the current requests and history.
  always_comb begin
    gnt_valid = ic_valid | dc_valid;
    gnt_owner = rr2_pick(ic_valid, dc_valid, last_q);
  end

  // History only moves when a grant is actually taken; starts at IC so the
  // first conflict after reset goes to the D-cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= ARB_OWN_IC;
    end else if (grant_en && gnt_valid) begin
      last_q <= gnt_owner;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single main-memory port between the I-cache
// refill path and the D-cache refill/writeback path. One burst at a time:
// grant, forward the command, count the beats, route data, release.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int AW    = ARB_AW,
  parameter int DW    = ARB_DW,
  parameter int BURST = ARB_BURST
) (
  input  logic                clk,
  input  logic                reset,
  cache_mem_arbiter_if.master bus,
  output logic                busy,
  output arb_state_e          state_dbg,
  output arb_owner_e          owner_dbg
);

  localparam int            CW        = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [DW-1:0] ZERO_DATA = '0;

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic          rnw_q, rnw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          gnt_valid;
  arb_owner_e    gnt_owner;
  logic          grant_en;
  logic          wbeat;

  arb_rr2 u_rr2 (
    .clk       (clk),
    .reset     (reset),
    .ic_valid  (bus.ic_req_valid),
    .dc_valid  (bus.dc_req_valid),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  // A write beat moves only when the D-cache offers it and memory takes it.
  assign wbeat = bus.dc_wdata_valid & bus.mem_wdata_ready;

  // Next-state logic: grant in IDLE, wait for the memory command handshake,
  // then count read or write beats until the burst is complete.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    grant_en = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          grant_en = 1'b1;
          owner_d  = gnt_owner;
          state_d  = ARB_CMD;
          if (gnt_owner == ARB_OWN_DC) begin
            rnw_d  = bus.dc_req_rnw;
            addr_d = bus.dc_req_addr;
          end else begin
            // The I-cache only ever reads.
            rnw_d  = 1'b1;
            addr_d = bus.ic_req_addr;
          end
        end
      end
      ARB_CMD: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = rnw_q ? ARB_RDATA : ARB_WDATA;
        end
      end
      ARB_RDATA: begin
        if (bus.mem_resp_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) state_d = ARB_IDLE;
        end
      end
      ARB_WDATA: begin
        if (wbeat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, latched command and beat counter; reset clears everything so the
  // command outputs read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWN_IC;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode: each path is opened only in the state that owns it, so
  // stray memory beats outside RDATA and early write data are ignored.
  always_comb begin
    bus.ic_req_ready    = 1'b0;
    bus.ic_resp_valid   = 1'b0;
    bus.ic_resp_data    = ZERO_DATA;
    bus.dc_req_ready    = 1'b0;
    bus.dc_wdata_ready  = 1'b0;
    bus.dc_resp_valid   = 1'b0;
    bus.dc_resp_data    = ZERO_DATA;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_rnw     = rnw_q;
    bus.mem_req_addr    = addr_q;
    bus.mem_wdata_valid = 1'b0;
    bus.mem_wdata       = ZERO_DATA;
    case (state_q)
      ARB_CMD: begin
        bus.mem_req_valid = 1'b1;
        if (owner_q == ARB_OWN_DC) bus.dc_req_ready = bus.mem_req_ready;
        else                       bus.ic_req_ready = bus.mem_req_ready;
      end
      ARB_RDATA: begin
        if (bus.mem_resp_valid) begin
          if (owner_q == ARB_OWN_DC) begin
            bus.dc_resp_valid = 1'b1;
            bus.dc_resp_data  = bus.mem_resp_data;
          end else begin
            bus.ic_resp_valid = 1'b1;
            bus.ic_resp_data  = bus.mem_resp_data;
          end
        end
      end
      ARB_WDATA: begin
        bus.mem_wdata_valid = bus.dc_wdata_valid;
        bus.dc_wdata_ready  = bus.mem_wdata_ready;
        bus.mem_wdata       = bus.dc_wdata;
      end
      default: begin
      end
    endcase
  end

  assign busy      = (state_q != ARB_IDLE);
  assign state_dbg = state_q;
  assign owner_dbg = owner_q;

endmodule
